// File: rtl/mul_scheduler.sv
// Round-robin scheduler sharing one multicycle 32x32 signed multiplier between NUM_REQ requesters.
// Define MUL_STICKY_OVF_EN to add the sticky overflow flag (ovf_sticky / ovf_clear).
module mul_scheduler #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ID_W       = 1,
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [31:0]           resp_out,
  output logic                  resp_ovf,
`ifdef MUL_STICKY_OVF_EN
  output logic                  ovf_sticky,
  input  logic                  ovf_clear,
`endif
  output logic                  busy
);

  localparam int unsigned CntW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     op_a_q, op_a_d;
  logic [31:0]     op_b_q, op_b_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            resp_valid_q, resp_valid_d;
  logic [31:0]     resp_out_q, resp_out_d;
  logic            resp_ovf_q, resp_ovf_d;
  logic [ID_W-1:0] resp_id_q, resp_id_d;

  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] rr_next;
  logic [31:0]     sel_a, sel_b;
  logic [63:0]     prod;
  logic            prod_ovf;
  logic            capture;

  // Two passes give the first valid index at or above rr_ptr, then wrap to the bottom.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[i] && (i >= int'(rr_ptr_q))) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[i] && (i < int'(rr_ptr_q))) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(i);
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_a = req_a[32*i +: 32];
        sel_b = req_b[32*i +: 32];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if ((state_q == StIdle) && !rst && grant_found) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        req_ready[i] = (grant_idx == ID_W'(i));
      end
    end
  end

  assign rr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

  // Sign-extended 64-bit unsigned multiply yields the exact signed product.
  assign prod     = {{32{op_a_q[31]}}, op_a_q} * {{32{op_b_q[31]}}, op_b_q};
  assign prod_ovf = (prod[63:32] != {32{prod[31]}});
  assign capture  = (state_q == StExec) && (cnt_q == '0);

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    id_d         = id_q;
    resp_valid_d = resp_valid_q;
    resp_out_d   = resp_out_q;
    resp_ovf_d   = resp_ovf_q;
    resp_id_d    = resp_id_q;
    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          op_a_d   = sel_a;
          op_b_d   = sel_b;
          id_d     = grant_idx;
          cnt_d    = CntW'(MUL_CYCLES - 1);
          rr_ptr_d = rr_next;
          state_d  = StExec;
        end
      end
      StExec: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          resp_out_d   = prod[31:0];
          resp_ovf_d   = prod_ovf;
          resp_id_d    = id_q;
          resp_valid_d = 1'b1;
          state_d      = StResp;
        end
      end
      StResp: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      id_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_out_q   <= '0;
      resp_ovf_q   <= 1'b0;
      resp_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      id_q         <= id_d;
      resp_valid_q <= resp_valid_d;
      resp_out_q   <= resp_out_d;
      resp_ovf_q   <= resp_ovf_d;
      resp_id_q    <= resp_id_d;
    end
  end

`ifdef MUL_STICKY_OVF_EN
  logic sticky_q, sticky_d;

  // Set has priority over a same-cycle clear.
  always_comb begin
    sticky_d = sticky_q;
    if (ovf_clear) sticky_d = 1'b0;
    if (capture && prod_ovf) sticky_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end

  assign ovf_sticky = sticky_q;
`else
  logic unused_capture;
  assign unused_capture = capture;
`endif

  assign resp_valid = resp_valid_q;
  assign resp_out   = resp_out_q;
  assign resp_ovf   = resp_ovf_q;
  assign resp_id    = resp_id_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_mul_scheduler.sv
// Scoreboard bench for mul_scheduler: directed vectors, decoupled response monitor.
// Covers the sticky overflow ports when MUL_STICKY_OVF_EN is defined.
module tb_mul_scheduler;

  localparam int NUM_REQ    = 2;
  localparam int ID_W       = 1;
  localparam int MUL_CYCLES = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a, req_b;
  logic                  resp_valid, resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_out;
  logic                  resp_ovf, busy;
`ifdef MUL_STICKY_OVF_EN
  logic                  ovf_sticky, ovf_clear;
`endif

  mul_scheduler #(
    .NUM_REQ   (NUM_REQ),
    .ID_W      (ID_W),
    .MUL_CYCLES(MUL_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_id   (resp_id),
    .resp_out  (resp_out),
    .resp_ovf  (resp_ovf),
`ifdef MUL_STICKY_OVF_EN
    .ovf_sticky(ovf_sticky),
    .ovf_clear (ovf_clear),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     out;
    logic            ovf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int id, input logic [31:0] out, input logic ovf);
    exp_t e;
    e.id  = ID_W'(id);
    e.out = out;
    e.ovf = ovf;
    sb.push_back(e);
  endtask

  // Monitor: compare every completed response handshake against the scoreboard.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got id %0d out %0h, expected none", resp_id, resp_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_id", 64'(resp_id), 64'(e.id));
        check("resp_out", 64'(resp_out), 64'(e.out));
        check("resp_ovf", 64'(resp_ovf), 64'(e.ovf));
      end
    end
  end

  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eo, input logic eovf, input bit do_push);
    bit got;
    got = 1'b0;
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
    req_valid[id]      = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        got = 1'b1;
        break;
      end
    end
    check("grant", 64'(got), 64'(1));
    if (got && do_push) push(id, eo, eovf);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
    check("drain", 64'(sb.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  int exp_order[4] = '{0, 1, 0, 1};

  initial begin
    bit saw;
    bit after_grant;
    int grants;
    rst        = 1'b1;
    req_valid  = '1;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
`ifdef MUL_STICKY_OVF_EN
    ovf_clear  = 1'b0;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = '0;
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_resp_out", 64'(resp_out), 64'(0));
    check("rst_resp_ovf", 64'(resp_ovf), 64'(0));
    check("rst_resp_id", 64'(resp_id), 64'(0));
`ifdef MUL_STICKY_OVF_EN
    check("rst_sticky", 64'(ovf_sticky), 64'(0));
`endif

    // Latency: accepted at edge 0, resp_valid after edge 2
    req_a[31:0]  = 32'd7;
    req_b[31:0]  = 32'hFFFF_FFFD;
    req_valid[0] = 1'b1;
    @(negedge clk);
    check("lat_grant", 64'(req_ready), 64'(2'b01));
    push(0, 32'hFFFF_FFEB, 1'b0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("lat_e0_valid", 64'(resp_valid), 64'(0));
    check("lat_e0_busy", 64'(busy), 64'(1));
    @(posedge clk); #1;
    check("lat_e1_valid", 64'(resp_valid), 64'(0));
    @(posedge clk); #1;
    check("lat_e2_valid", 64'(resp_valid), 64'(1));
    drain();

    // Overflow vectors
    issue(1, 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1, 1'b1);
    drain();
    issue(0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);
    drain();
    issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
    drain();
`ifdef MUL_STICKY_OVF_EN
    ovf_clear = 1'b1;
    @(posedge clk); #1;
    ovf_clear = 1'b0;
    check("sticky_cleared0", 64'(ovf_sticky), 64'(0));
`endif
    issue(0, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, 1'b1);
    drain();
`ifdef MUL_STICKY_OVF_EN
    check("sticky_set", 64'(ovf_sticky), 64'(1));
`endif
    issue(1, 32'd3, 32'd4, 32'd12, 1'b0, 1'b1);
    drain();
`ifdef MUL_STICKY_OVF_EN
    check("sticky_hold", 64'(ovf_sticky), 64'(1));
    ovf_clear = 1'b1;
    @(posedge clk); #1;
    ovf_clear = 1'b0;
    check("sticky_clear", 64'(ovf_sticky), 64'(0));
`endif

    // Round-robin with both requesters continuously valid
    pulse_reset();
    req_a       = {32'd5, 32'd2};
    req_b       = {32'hFFFF_FFFE, 32'd3};
    req_valid   = 2'b11;
    grants      = 0;
    after_grant = 1'b0;
    for (int cyc = 0; cyc < 200 && grants < 4; cyc++) begin
      @(negedge clk);
      if (after_grant) check("rr_pulse_len", 64'(req_ready), 64'(0));
      after_grant = 1'b0;
      if (req_ready != '0) begin
        check("rr_order", 64'(req_ready), 64'(2'b01 << exp_order[grants]));
        check("rr_idle", 64'(busy), 64'(0));
        if (exp_order[grants] == 0) push(0, 32'd6, 1'b0);
        else                        push(1, 32'hFFFF_FFF6, 1'b0);
        grants++;
        after_grant = 1'b1;
      end
    end
    check("rr_grants", 64'(grants), 64'(4));
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    if (after_grant) check("rr_pulse_len", 64'(req_ready), 64'(0));
    drain();

    // Backpressure: hold response for 5 cycles with a competing request pending
    resp_ready = 1'b0;
    issue(1, 32'hFFFF_FFFB, 32'd6, 32'hFFFF_FFE2, 1'b0, 1'b1);
    req_a[31:0]  = 32'd1;
    req_b[31:0]  = 32'd1;
    req_valid[0] = 1'b1;
    saw = 1'b0;
    for (int n = 0; n < 20 && !saw; n++) begin
      @(negedge clk);
      saw = resp_valid;
    end
    check("bp_valid", 64'(saw), 64'(1));
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("bp_out", 64'(resp_out), 64'(32'hFFFF_FFE2));
      check("bp_ovf", 64'(resp_ovf), 64'(0));
      check("bp_id", 64'(resp_id), 64'(1));
      check("bp_ready", 64'(req_ready), 64'(0));
    end
    @(posedge clk); #1;
    req_valid  = '0;
    resp_ready = 1'b1;
    drain();

    // Reset during EXEC discards the operation and restores rr_ptr
    issue(0, 32'd9, 32'd9, 32'd81, 1'b0, 1'b0);
    check("exec_busy", 64'(busy), 64'(1));
    pulse_reset();
    check("rexec_busy", 64'(busy), 64'(0));
    check("rexec_valid", 64'(resp_valid), 64'(0));
    saw = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (resp_valid) saw = 1'b1;
    end
    check("rexec_no_resp", 64'(saw), 64'(0));
    @(posedge clk); #1;
    req_a     = {32'd1, 32'd4};
    req_b     = {32'd1, 32'd5};
    req_valid = 2'b11;
    @(negedge clk);
    check("rexec_grant", 64'(req_ready), 64'(2'b01));
    if (req_ready == 2'b01) push(0, 32'd20, 1'b0);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
